// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and elaboration-time helpers for tick_gen.
//   ACC_W_DEF    default accumulator / increment width
//   DEF_INC_1KHZ reset increment giving 1 kHz from 50 MHz at ACC_W_DEF bits
//   freq_to_inc  round(2^acc_w * fout / fin), for constant increments in parents
package tick_gen_pkg;

  localparam int unsigned     ACC_W_DEF    = 32;
  localparam longint unsigned DEF_INC_1KHZ = 64'd85899;

  // Rounded phase increment; 128-bit intermediate so acc_w up to 48 cannot overflow.
  function automatic longint unsigned freq_to_inc(
    input longint unsigned freq_in_hz,
    input longint unsigned freq_out_hz,
    input int unsigned     acc_w
  );
    logic [127:0] num;
    num = (128'(freq_out_hz) << acc_w) + 128'(freq_in_hz >> 1);
    return 64'(num / 128'(freq_in_hz));
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one phase-accumulator channel of tick_gen.
//   clk_in  clock
//   rst     synchronous active-high reset (inc <= DEF_INC, everything else 0)
//   en      run enable; while low acc holds and tick is 0
//   clr     phase align: acc, tick (and sq) cleared, wins over en
//   ld      load ld_val into inc; acc is untouched, new inc used from next edge
//   ld_val  new increment
//   tick    registered carry-out of acc + inc
//   sq      square wave from acc MSB (only built with TICK_GEN_SQUARE_EN)
// Optional feature macro: TICK_GEN_SQUARE_EN.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int unsigned     ACC_W   = ACC_W_DEF,
  parameter longint unsigned DEF_INC = DEF_INC_1KHZ
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [ACC_W-1:0] ld_val,
  output logic             tick,
  output logic             sq
);

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_c;

  // One extra bit: the carry out is the tick.
  assign sum_c = {1'b0, acc} + {1'b0, inc};

  // Increment, accumulator and tick registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      inc  <= ACC_W'(DEF_INC);
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      if (ld) begin
        inc <= ld_val;
      end
      if (clr) begin
        acc  <= '0;
        tick <= 1'b0;
      end else if (en) begin
        acc  <= sum_c[ACC_W-1:0];
        tick <= sum_c[ACC_W];
      end else begin
        tick <= 1'b0;
      end
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  // Square wave follows the current phase MSB; frozen with the accumulator.
  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      sq <= 1'b0;
    end else if (en) begin
      sq <= acc[ACC_W-1];
    end
  end
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel fractional tick generator (one-cycle enable strobes).
//   clk_in   sole clock
//   rst      synchronous active-high reset
//   en       per-channel run enable [N_CH]
//   sync     clear all accumulators (phase align)
//   wr_en    increment write strobe
//   wr_ch    target channel for the write
//   wr_data  new increment [ACC_W]
//   wr_err   one-cycle pulse when a write targets a channel >= N_CH
//   tick     one-cycle strobe per channel [N_CH]
//   sq_out   ~50% square wave per channel, 0 unless TICK_GEN_SQUARE_EN is defined
// Optional feature macro: TICK_GEN_SQUARE_EN.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned     FREQ_IN = 50,
  parameter int unsigned     N_CH    = 4,
  parameter int unsigned     ACC_W   = ACC_W_DEF,
  parameter longint unsigned DEF_INC = DEF_INC_1KHZ,
  localparam int unsigned    CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [ACC_W-1:0] wr_data,
  output logic             wr_err,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  sq_out
);

  // Reject unsupported configurations at elaboration.
  if (N_CH < 1 || N_CH > 16 || ACC_W < 8 || ACC_W > 48 || FREQ_IN == 0) begin : g_bad_param
    $error("tick_gen: unsupported parameter set");
  end

  logic wr_ok_c;

  // wr_ch can encode values beyond N_CH when N_CH is not a power of two.
  assign wr_ok_c = wr_en && (32'(wr_ch) < N_CH);

  // Out-of-range write flag, registered like tick.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok_c;
    end
  end

  // Channel array; sync is the only cross-channel coupling.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ld_c;
    assign ld_c = wr_ok_c && (wr_ch == CH_W'(i));

    tick_gen_ch #(
      .ACC_W   (ACC_W),
      .DEF_INC (DEF_INC)
    ) u_ch (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en[i]),
      .clr    (sync),
      .ld     (ld_c),
      .ld_val (wr_data),
      .tick   (tick[i]),
      .sq     (sq_out[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: scoreboard bench for tick_gen. Two instances share all stimulus:
// u_dut (N_CH=4) and u_dut3 (N_CH=3, where wr_ch=3 is out of range).
// Expected ticks use the rational rate inc/2^32 = num/den per channel with n
// counted in enabled edges since the last alignment.
module tb_tick_gen;

`ifdef TICK_GEN_SQUARE_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  en = '0;
  logic        sync = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [31:0] wr_data = '0;
  logic        wr_err, wr_err3;
  logic [3:0]  tick, sq_out;
  logic [2:0]  tick3, sq3;

  always #5 clk_in = ~clk_in;

  tick_gen #(.N_CH(4), .ACC_W(32)) u_dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .wr_err(wr_err), .tick(tick), .sq_out(sq_out)
  );

  tick_gen #(.N_CH(3), .ACC_W(32)) u_dut3 (
    .clk_in(clk_in), .rst(rst), .en(en[2:0]), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .wr_err(wr_err3), .tick(tick3), .sq_out(sq3)
  );

  typedef struct {
    logic [3:0] tick;
    logic       err;
    logic [2:0] tick3;
    logic       err3;
    logic [3:0] sq;
    bit         win_start;
    bit         win_end;
    int         c0;
    int         c1;
  } exp_t;

  exp_t    sb[$];
  int      checks = 0;
  int      failures = 0;
  longint  n[4];
  longint  num[4];
  longint  den[4];

  // Tick on the edge where floor(n*num/den) steps up.
  function automatic logic f_tick(input longint nn, input longint nu, input longint de);
    if (nn == 0 || nu == 0) return 1'b0;
    return ((nn * nu) / de) != (((nn - 1) * nu) / de);
  endfunction

  // Square wave = MSB of the phase before the latest enabled edge.
  function automatic logic f_sq(input longint nn, input longint nu, input longint de);
    if (nn == 0 || nu == 0) return 1'b0;
    return (((2 * (nn - 1) * nu) / de) % 2) == 1;
  endfunction

  // Drive one cycle, push its expected response, return 2 units after the edge.
  task automatic cyc(input logic r, input logic [3:0] e, input logic s, input logic we,
                     input logic [1:0] wch, input logic [31:0] wd, input longint wnum,
                     input longint wden, input bit ws, input bit wend, input int ec0,
                     input int ec1);
    exp_t x;
    rst = r; en = e; sync = s; wr_en = we; wr_ch = wch; wr_data = wd;
    x.tick = '0; x.sq = '0;
    for (int c = 0; c < 4; c++) begin
      if (r) begin
        n[c] = 0; num[c] = 0; den[c] = 1;
      end else if (s) begin
        n[c] = 0;
      end else if (e[c]) begin
        n[c] = n[c] + 1;
        x.tick[c] = f_tick(n[c], num[c], den[c]);
      end
      x.sq[c] = SQ_EN && f_sq(n[c], num[c], den[c]);
    end
    x.err = 1'b0;
    x.err3 = !r && we && (wch == 2'd3);
    x.tick3 = x.tick[2:0];
    x.win_start = ws; x.win_end = wend; x.c0 = ec0; x.c1 = ec1;
    if (!r && we) begin
      num[wch] = wnum; den[wch] = wden;
    end
    sb.push_back(x);
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle(input logic [3:0] e, input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, e, 1'b0, 1'b0, 2'd0, 32'd0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [3:0] e, input logic s, input logic [1:0] wch,
                    input logic [31:0] wd, input longint wnum, input longint wden);
    cyc(1'b0, e, s, 1'b1, wch, wd, wnum, wden, 0, 0, 0, 0);
  endtask

  // Monitor: one popped entry per edge with stimulus.
  exp_t mx;
  int   cnt0, cnt1, consec;
  logic prev1;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  always @(posedge clk_in) begin
    #1;
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      chk("tick", tick, mx.tick);
      chk("wr_err", {3'b0, wr_err}, {3'b0, mx.err});
      chk("tick_n3", {1'b0, tick3}, {1'b0, mx.tick3});
      chk("wr_err_n3", {3'b0, wr_err3}, {3'b0, mx.err3});
      chk("sq_out", sq_out, mx.sq);
      chk("sq_out_n3", {1'b0, sq3}, {1'b0, mx.sq[2:0]});
      if (mx.win_start) begin
        cnt0 = 0; cnt1 = 0; consec = 0; prev1 = 1'b0;
      end
      cnt0 = cnt0 + int'(tick[0]);
      cnt1 = cnt1 + int'(tick[1]);
      if (tick[1] && prev1) consec++;
      prev1 = tick[1];
      if (mx.win_end) begin
        chk_int("ticks_ch0_window", cnt0, mx.c0);
        chk_int("ticks_ch1_window", cnt1, mx.c1);
        chk_int("ch1_back_to_back", consec, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t run did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: all outputs 0.
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 32'd0, 0, 1, 0, 0, 0, 0);
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 32'd0, 0, 1, 0, 0, 0, 0);
    // Program rates while halted: 1/4, 3/8, 1/4, 1/8 (ch3 write is out of range for u_dut3).
    wr(4'h0, 1'b0, 2'd0, 32'h4000_0000, 1, 4);
    wr(4'h0, 1'b0, 2'd1, 32'h6000_0000, 3, 8);
    wr(4'h0, 1'b0, 2'd2, 32'h4000_0000, 1, 4);
    wr(4'h0, 1'b0, 2'd3, 32'h2000_0000, 1, 8);
    // 1000-cycle window: 250 ticks on ch0, 375 on ch1, never two ch1 ticks in a row.
    for (int i = 0; i < 1000; i++)
      cyc(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0, 0, 1, i == 0, i == 999, 250, 375);
    // Mid-run write of ch2 = 1/2 on the 7th edge; acc must carry over.
    for (int i = 0; i < 16; i++) begin
      if (i == 6) wr(4'hF, 1'b0, 2'd2, 32'h8000_0000, 1, 2);
      else idle(4'hF, 1);
    end
    // Sync on an edge where ch0 and ch2 would tick, with a ch3 write on the same edge.
    idle(4'hF, 3);
    wr(4'hF, 1'b1, 2'd3, 32'h4000_0000, 1, 4);
    idle(4'hF, 8);
    // ch3 paused mid-period for 10 cycles, then resumes from the held phase.
    idle(4'hF, 2);
    idle(4'h7, 10);
    idle(4'hF, 4);
    // Out-of-range write for u_dut3: single wr_err pulse, its channels unaffected.
    wr(4'hF, 1'b0, 2'd3, 32'h4000_0000, 1, 4);
    idle(4'hF, 3);
    // Reset mid-run overrides a simultaneous write; increments return to default.
    cyc(1'b1, 4'hF, 1'b0, 1'b1, 2'd0, 32'h8000_0000, 1, 2, 0, 0, 0, 0);
    idle(4'hF, 10);
    // Sync with a write of ch0 = 1/8: tick every 8th edge, square wave 4 low / 4 high.
    wr(4'hF, 1'b1, 2'd0, 32'h2000_0000, 1, 8);
    idle(4'hF, 24);
    idle(4'h0, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
